// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared field encoding and parity constants for the UART TX sequencer
package uart_tx_pkg;
  typedef enum logic [2:0] {
    F_IDLE   = 3'd0,
    F_START  = 3'd1,
    F_DATA   = 3'd2,
    F_PARITY = 3'd3,
    F_STOP   = 3'd4
  } field_e;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/uart_tx_parity.sv
// uart_tx_parity: combinational even/odd parity over a DATA_WIDTH-bit word
module uart_tx_parity
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  par_o
);
  assign par_o = (^data_i) ^ (par_typ_i == PAR_ODD);
endmodule

// File: rtl/uart_tx_frame_seq.sv
// uart_tx_frame_seq: start/data/parity/stop frame sequencer driving a registered serial line
module uart_tx_frame_seq
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  BIT_TICK,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic [2:0]            FIELD
);
  localparam int CW = $clog2(DATA_WIDTH);
  field_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_nx;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic stop_q, stop_d, par_en_q, par_en_d, par_typ_q, par_typ_d, stop2_q, stop2_d;
  logic tx_q, tx_d, busy_q, busy_d, par, last_stop, accept;
  uart_tx_parity #(.DATA_WIDTH(DATA_WIDTH)) u_par (
    .data_i   (data_q),
    .par_typ_i(par_typ_q),
    .par_o    (par)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= F_IDLE;
      cnt_q     <= '0;
      stop_q    <= 1'b0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stop_q    <= stop_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end
  // A new word may be taken on the tick that closes the last stop bit, giving gapless frames
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stop_d    = stop_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    stop2_d   = stop2_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    cnt_nx    = cnt_q + CW'(1);
    last_stop = (state_q == F_STOP) && (!stop2_q || stop_q);
    accept    = DATA_VALID && BIT_TICK && ((state_q == F_IDLE) || last_stop);
    if (accept) begin
      state_d   = F_START;
      data_d    = P_DATA;
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
      stop2_d   = STOP2;
      cnt_d     = '0;
      stop_d    = 1'b0;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
    end else if (BIT_TICK) begin
      case (state_q)
        F_START: begin
          state_d = F_DATA;
          cnt_d   = '0;
          tx_d    = data_q[0];
        end
        F_DATA: begin
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? F_PARITY : F_STOP;
            tx_d    = par_en_q ? par : 1'b1;
            stop_d  = 1'b0;
          end else begin
            cnt_d = cnt_nx;
            tx_d  = data_q[cnt_nx];
          end
        end
        F_PARITY: begin
          state_d = F_STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
        F_STOP: begin
          state_d = last_stop ? F_IDLE : F_STOP;
          busy_d  = !last_stop;
          stop_d  = !last_stop;
          tx_d    = 1'b1;
        end
        default: begin
          state_d = F_IDLE;
          busy_d  = 1'b0;
          tx_d    = 1'b1;
        end
      endcase
    end
  end
  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;
  assign FIELD  = state_q;
endmodule
